fixed_to_ieee754: RTL and testbench

Output converter for the fixed-point filter datapath. It takes the wide signed fixed-point samples produced by the lowpass biquad sections and converts each one to an IEEE-754 single-precision word. It is a 3-stage pipeline with valid/ready handshakes on input and output, and it sits directly downstream of the section output y.

---
 rtl/fixed_to_ieee754_if.sv | 34 +++
 rtl/fixed_to_ieee754.sv | 141 ++++++++++++++
 tb/tb_fixed_to_ieee754.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fixed_to_ieee754_if.sv
// Sample-in / float-out stream bundle for the fixed-to-float converter.
// Carries both valid/ready handshakes plus the fixed-point and IEEE-754 payloads.
// master drives samples and accepts results; slave is the converter side.
interface fixed_to_ieee754_if #(
    parameter int DATA_W = 77
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              out_inexact;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_inexact
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_inexact
    );
endinterface

// File: rtl/fixed_to_ieee754.sv
// Converts signed DATA_W-bit fixed point (FRAC_W fraction bits) to IEEE-754 single, round-to-nearest-even.
// Latency: 3 advancing cycles (sign/magnitude, normalize, round/pack); 1 sample per cycle.
// Backpressure: all stages stall together while out_valid && !out_ready; in_ready is the advance term.
module fixed_to_ieee754 #(
    parameter int DATA_W = 77,
    parameter int FRAC_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    fixed_to_ieee754_if.slave  bus
);
    localparam int         PW      = $clog2(DATA_W);
    localparam logic [9:0] EXP_OFF = 10'(127 - FRAC_W);

    // Whole pipeline moves as one unit: a stalled output freezes everything upstream.
    logic advance;

    // Stage 1 registers: sign, magnitude, zero flag.
    logic              s1_vld;
    logic              s1_sign;
    logic              s1_zero;
    logic [DATA_W-1:0] s1_mag;

    // Stage 2 registers: normalized magnitude (leading one at MSB) and biased exponent.
    logic              s2_vld;
    logic              s2_sign;
    logic              s2_zero;
    logic [DATA_W-1:0] s2_norm;
    logic [7:0]        s2_exp;

    // Stage 3 (output) registers.
    logic        out_vld_q;
    logic [31:0] out_dat_q;
    logic        out_inx_q;

    // Combinational intermediates.
    logic [DATA_W-1:0] in_mag;
    logic [PW-1:0]     lead;
    logic [PW-1:0]     shamt;
    logic [DATA_W-1:0] norm;
    logic [9:0]        e_calc;
    logic [23:0]       mant;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [24:0]       mant_r;
    logic              carry;
    logic [7:0]        exp_f;
    logic [22:0]       frac;
    logic [31:0]       word;
    logic              inexact;

    assign advance         = !out_vld_q || bus.out_ready;
    assign bus.in_ready    = advance;
    assign bus.out_valid   = out_vld_q;
    assign bus.out_data    = out_dat_q;
    assign bus.out_inexact = out_inx_q;

    // Absolute value in DATA_W unsigned bits; the most negative input maps to 2^(DATA_W-1) without wrapping.
    always_comb begin
        in_mag = bus.in_data;
        if (bus.in_data[DATA_W-1]) begin
            in_mag = ~bus.in_data + DATA_W'(1);
        end
    end

    // Stage 1 register: capture sign, magnitude and zero flag of the accepted sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
        end else if (advance) begin
            s1_vld  <= bus.in_valid;
            s1_sign <= bus.in_data[DATA_W-1];
            s1_mag  <= in_mag;
            s1_zero <= (bus.in_data == '0);
        end
    end

    // Leading-one position, left shift to put it at the MSB, and the biased exponent.
    always_comb begin
        lead = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (s1_mag[i]) begin
                lead = PW'(i);
            end
        end
        shamt  = PW'(DATA_W - 1) - lead;
        norm   = s1_mag << shamt;
        e_calc = 10'(lead) + EXP_OFF;
    end

    // Stage 2 register: normalized magnitude and exponent; exponent range is checked in simulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
        end else if (advance) begin
            if (s1_vld && !s1_zero) begin
                assert ($signed(e_calc) >= 1 && $signed(e_calc) <= 254);
            end
            s2_vld  <= s1_vld;
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_norm <= norm;
            s2_exp  <= e_calc[7:0];
        end
    end

    // Round-to-nearest-even on the 24-bit mantissa; a carry out renormalizes to 1.0 and bumps the exponent.
    // Small magnitudes were zero-filled by the shift, so guard and sticky are naturally zero for them.
    always_comb begin
        mant     = s2_norm[DATA_W-1 -: 24];
        guard    = s2_norm[DATA_W-25];
        sticky   = |s2_norm[DATA_W-26:0];
        round_up = guard && (sticky || mant[0]);
        mant_r   = {1'b0, mant} + 25'(round_up);
        carry    = mant_r[24];
        exp_f    = s2_exp + 8'(carry);
        frac     = carry ? mant_r[23:1] : mant_r[22:0];
        word     = {s2_sign, exp_f, frac};
        inexact  = guard || sticky;
        if (s2_zero) begin
            word    = 32'h0000_0000;
            inexact = 1'b0;
        end
    end

    // Output register: holds its word while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_dat_q <= 32'h0000_0000;
            out_inx_q <= 1'b0;
        end else if (advance) begin
            out_vld_q <= s2_vld;
            if (s2_vld) begin
                out_dat_q <= word;
                out_inx_q <= inexact;
            end
        end
    end
endmodule

// File: tb/tb_fixed_to_ieee754.sv
// Bench for fixed_to_ieee754: vector table fed through a scoreboard queue,
// plus hand sequences for backpressure, mid-stream reset and bubbles.
module tb_fixed_to_ieee754;
    localparam int DATA_W = 77;
    localparam int FRAC_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fixed_to_ieee754_if #(.DATA_W(DATA_W)) bus ();

    fixed_to_ieee754 #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] din;
        logic [31:0]       dat;
        logic              inx;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        inx;
        int          acc_cyc;
    } sb_t;

    vec_t        vecs[12];
    sb_t         sbq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_out = 0;
    bit          lat_chk = 1'b0;
    bit          bub_chk = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          last_acc = 1'b0;
    bit          stall_prev = 1'b0;
    bit          acc_hist[0:4095];
    logic [31:0] held_dat;
    logic        held_inx;
    logic [31:0] cur_dat;
    logic        cur_inx;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Observes one cycle at the falling edge: handshake rules, hold stability, scoreboard.
    task automatic monitor();
        sb_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
            last_acc   = 1'b0;
            acc_hist[cyc] = 1'b0;
            return;
        end
        chk("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
        if (stall_prev) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", bus.out_data, held_dat);
            chk("hold_inexact", 32'(bus.out_inexact), 32'(held_inx));
        end
        if (bub_chk && cyc >= 3) begin
            chk("bubble_valid", 32'(bus.out_valid), 32'(acc_hist[cyc-3]));
        end
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%08h, expected no output (cycle %0d)", bus.out_data, cyc);
            end else begin
                e = sbq.pop_front();
                chk("out_data", bus.out_data, e.dat);
                chk("out_inexact", 32'(bus.out_inexact), 32'(e.inx));
                if (lat_chk) chk("latency", 32'(cyc - e.acc_cyc), 32'd3);
            end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        held_dat   = bus.out_data;
        held_inx   = bus.out_inexact;
        last_acc   = bus.in_valid && bus.in_ready;
        acc_hist[cyc] = last_acc;
        if (last_acc) sbq.push_back('{cur_dat, cur_inx, cyc});
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(input int k, input bit v);
        bus.in_valid = v;
        bus.in_data  = vecs[k].din;
        cur_dat      = vecs[k].dat;
        cur_inx      = vecs[k].inx;
    endtask

    task automatic send(input int k);
        int n = 0;
        drive(k, 1'b1);
        do begin
            tick();
            n++;
        end while (!last_acc && n < 100);
        chk("accept", 32'(last_acc), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid = 1'b0;
        while (sbq.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int out_before;

        vecs[0]  = '{DATA_W'(1) << 32,              32'h3F80_0000, 1'b0}; // 1.0
        vecs[1]  = '{-(DATA_W'(5) << 31),           32'hC020_0000, 1'b0}; // -2.5
        vecs[2]  = '{'0,                            32'h0000_0000, 1'b0}; // zero
        vecs[3]  = '{DATA_W'(1),                    32'h2F80_0000, 1'b0}; // 2^-32
        vecs[4]  = '{DATA_W'(1) << 76,              32'hD580_0000, 1'b0}; // -2^76 raw
        vecs[5]  = '{(DATA_W'(1) << 24) + 1,        32'h3B80_0000, 1'b1}; // tie, stays even
        vecs[6]  = '{(DATA_W'(1) << 24) + 3,        32'h3B80_0002, 1'b1}; // tie, rounds up
        vecs[7]  = '{(DATA_W'(1) << 25) - 1,        32'h3C00_0000, 1'b1}; // mantissa carry
        vecs[8]  = '{'1,                            32'hAF80_0000, 1'b0}; // -2^-32
        vecs[9]  = '{DATA_W'(3) << 32,              32'h4040_0000, 1'b0}; // 3.0
        vecs[10] = '{(DATA_W'(1) << 25) + 3,        32'h3C00_0001, 1'b1}; // guard+sticky
        vecs[11] = '{{1'b0, {(DATA_W-1){1'b1}}},    32'h5580_0000, 1'b1}; // max positive

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        cur_dat       = '0;
        cur_inx       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'h0000_0000);
        chk("rst_out_inexact", 32'(bus.out_inexact), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // Table vectors back to back with latency check
        lat_chk = 1'b1;
        for (int k = 0; k < 12; k++) send(k);
        drain();

        // Backpressure: 10 samples, random out_ready
        lat_chk    = 1'b0;
        rand_rdy   = 1'b1;
        out_before = n_out;
        for (int i = 0; i < 10; i++) send((i + 3) % 12);
        drain();
        rand_rdy      = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_count", 32'(n_out - out_before), 32'd10);

        // Bubbles: in_valid 1,0,1,0,1,0
        repeat (3) tick();
        lat_chk = 1'b1;
        bub_chk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(i + 4, (i % 2) == 0);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (4) tick();
        drain();
        bub_chk = 1'b0;

        // Reset while three samples are in flight
        lat_chk       = 1'b0;
        bus.out_ready = 1'b0;
        send(5);
        send(6);
        send(7);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        sbq.delete();
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        lat_chk       = 1'b1;
        out_before    = n_out;
        send(9);
        drain();
        repeat (6) tick();
        chk("rst_mid_count", 32'(n_out - out_before), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
